// File: rtl/sgd_weight_update_pkg.sv
// Q-format helpers shared by the SGD update block and future arithmetic
// stages: default word layout, range limits, rounding constant and a
// saturate-to-width function usable for any word width up to 63 bits.
package sgd_weight_update_pkg;

  localparam int Q_FIXED_BITS_DEF = 8;
  localparam int Q_FRAC_BITS_DEF  = 8;
  localparam int Q_W_DEF          = Q_FIXED_BITS_DEF + Q_FRAC_BITS_DEF;

  localparam logic signed [Q_W_DEF-1:0] Q_MAX_DEF = 16'sh7FFF;
  localparam logic signed [Q_W_DEF-1:0] Q_MIN_DEF = 16'sh8000;

  // Half an LSB of the result: added before the arithmetic right shift so
  // that the shift rounds half-up instead of truncating toward -inf.
  function automatic logic signed [63:0] q_round_const(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

  // Clamp a sign-extended value into the signed range of a w-bit word.
  // The caller takes the low w bits of the result.
  function automatic logic signed [63:0] q_sat(input logic signed [63:0] x,
                                               input int w);
    logic signed [63:0] hi_s;
    logic signed [63:0] lo_s;
    hi_s = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_s = -(64'sd1 <<< (w - 1));
    if (x > hi_s) begin
      return hi_s;
    end else if (x < lo_s) begin
      return lo_s;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/sgd_weight_update_q_mul_round_sat.sv
// Combinational Q-format multiply: y = sat(round(a * b)), with the full
// 2W-bit product rounded half-up at the fractional point and clamped to W
// bits. Shared with the forward-pass MAC, so kept free of any control.
module q_mul_round_sat
  import sgd_weight_update_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  logic signed [2*W-1:0] p_raw_s;
  logic signed [2*W:0]   p_rnd_s;
  logic signed [2*W:0]   p_sh_s;

  // Full-precision product, half-LSB rounding, shift and saturation.
  // One guard bit on the rounded sum keeps (-2^(W-1))^2 + half from wrapping.
  always_comb begin
    p_raw_s = (2*W)'(a) * (2*W)'(b);
    p_rnd_s = (2*W+1)'(p_raw_s) + (2*W+1)'(q_round_const(FRAC));
    p_sh_s  = p_rnd_s >>> FRAC;
    y       = W'(q_sat(64'(p_sh_s), W));
  end

endmodule

// File: rtl/sgd_weight_update.sv
// One SGD step over a synchronous weight/gradient store: for each index,
// read w and g, compute w - sat(round(lr * g)) with saturation, write the
// new weight back and clear the matching gradient register. Three cycles
// per entry (RD, CALC, WR); every output is driven straight from a flop.
module sgd_weight_update
  import sgd_weight_update_pkg::*;
#(
  parameter int FIXED_BITS      = Q_FIXED_BITS_DEF,
  parameter int FRACTIONAL_BITS = Q_FRAC_BITS_DEF,
  parameter int NUM_WEIGHTS     = 16,
  parameter int ADDR_W          = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0] lr,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         rd_en,
  output logic        [ADDR_W-1:0]                     rd_addr,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0] weight_rd_data,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0] grad_rd_data,
  output logic                                         wr_en,
  output logic        [ADDR_W-1:0]                     wr_addr,
  output logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0] wr_data,
  output logic                                         grad_clear_en,
  output logic        [ADDR_W-1:0]                     grad_clear_addr
);

  localparam int W = FIXED_BITS + FRACTIONAL_BITS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CALC = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e                state_r, state_next_s;
  logic [ADDR_W-1:0]     idx_r, idx_next_s;
  logic signed [W-1:0]   lr_q_r, lr_next_s;

  logic signed [W-1:0]   prod_s;
  logic signed [W:0]     diff_s;
  logic signed [W-1:0]   upd_s;

  logic                  busy_next_s, done_next_s, rd_en_next_s, wr_en_next_s;
  logic [ADDR_W-1:0]     rd_addr_next_s, wr_addr_next_s;
  logic signed [W-1:0]   wr_data_next_s;

  // p = sat(round(lr_q * g)); the gradient is valid on the bus during CALC.
  q_mul_round_sat #(
    .W    (W),
    .FRAC (FRACTIONAL_BITS)
  ) u_mul (
    .a (lr_q_r),
    .b (grad_rd_data),
    .y (prod_s)
  );

  // New weight: subtract one bit wider than the word, then clamp. The result
  // is captured into wr_data at the CALC->WR edge, so p never needs its own
  // pipeline register.
  always_comb begin
    diff_s = (W+1)'(weight_rd_data) - (W+1)'(prod_s);
    upd_s  = W'(q_sat(64'(diff_s), W));
  end

  // Next state, index and learning-rate latch.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    lr_next_s    = lr_q_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RD;
          idx_next_s   = {ADDR_W{1'b0}};
          lr_next_s    = lr;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD:   state_next_s = ST_CALC;
      ST_CALC: state_next_s = ST_WR;
      ST_WR: begin
        if (idx_r < LAST_IDX) begin
          state_next_s = ST_RD;
          idx_next_s   = idx_r + IDX_ONE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the
  // strobes, addresses and data line up with the state they belong to.
  always_comb begin
    busy_next_s    = 1'b0;
    done_next_s    = 1'b0;
    rd_en_next_s   = 1'b0;
    wr_en_next_s   = 1'b0;
    rd_addr_next_s = {ADDR_W{1'b0}};
    wr_addr_next_s = {ADDR_W{1'b0}};
    wr_data_next_s = {W{1'b0}};
    case (state_next_s)
      ST_RD: begin
        busy_next_s    = 1'b1;
        rd_en_next_s   = 1'b1;
        rd_addr_next_s = idx_next_s;
      end
      ST_CALC: begin
        busy_next_s = 1'b1;
      end
      ST_WR: begin
        busy_next_s    = 1'b1;
        wr_en_next_s   = 1'b1;
        wr_addr_next_s = idx_next_s;
        wr_data_next_s = upd_s;
      end
      ST_DONE: begin
        done_next_s = 1'b1;
      end
      default: begin
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Control state: FSM, sweep index and learning rate held for the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {ADDR_W{1'b0}};
      lr_q_r  <= {W{1'b0}};
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      lr_q_r  <= lr_next_s;
    end
  end

  // Output registers; reset drops every strobe at once, aborting a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_en           <= 1'b0;
      rd_addr         <= {ADDR_W{1'b0}};
      wr_en           <= 1'b0;
      wr_addr         <= {ADDR_W{1'b0}};
      wr_data         <= {W{1'b0}};
      grad_clear_en   <= 1'b0;
      grad_clear_addr <= {ADDR_W{1'b0}};
    end else begin
      busy            <= busy_next_s;
      done            <= done_next_s;
      rd_en           <= rd_en_next_s;
      rd_addr         <= rd_addr_next_s;
      wr_en           <= wr_en_next_s;
      wr_addr         <= wr_addr_next_s;
      wr_data         <= wr_data_next_s;
      grad_clear_en   <= wr_en_next_s;
      grad_clear_addr <= wr_addr_next_s;
    end
  end

endmodule

// File: tb/tb_sgd_weight_update.sv
// Bench for sgd_weight_update: a behavioural weight/gradient store, a
// scoreboard of expected (address, weight) writes built from an independent
// reference model at start time, and one task per scenario.
module tb_sgd_weight_update;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] lr;
  logic        busy, done, rd_en, wr_en, grad_clear_en;
  logic [3:0]  rd_addr, wr_addr, grad_clear_addr;
  logic [15:0] weight_rd_data, grad_rd_data, wr_data;

  logic [15:0] mem_w [N];
  logic [15:0] mem_g [N];
  logic [19:0] exp_q [$];
  int          n_checks;
  int          n_pass;
  int          n_writes;

  sgd_weight_update #(
    .FIXED_BITS      (8),
    .FRACTIONAL_BITS (8),
    .NUM_WEIGHTS     (N),
    .ADDR_W          (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .lr              (lr),
    .busy            (busy),
    .done            (done),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .weight_rd_data  (weight_rd_data),
    .grad_rd_data    (grad_rd_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .grad_clear_en   (grad_clear_en),
    .grad_clear_addr (grad_clear_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: w - sat(round_half_up(lr*g / 2^8)), clamped to 16 bits.
  function automatic logic [15:0] model_upd(input logic [15:0] w,
                                            input logic [15:0] g,
                                            input logic [15:0] l);
    longint pr, p, d;
    pr = longint'($signed(l)) * longint'($signed(g));
    p  = (pr + 128) >>> 8;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    d = longint'($signed(w)) - p;
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  // Store model: read data one cycle after rd_en, weight writes on wr_en.
  always @(posedge clk) begin
    if (rd_en) begin
      weight_rd_data <= mem_w[rd_addr];
      grad_rd_data   <= mem_g[rd_addr];
    end
    if (wr_en) mem_w[wr_addr] = wr_data;
  end

  // Scoreboard and strobe hygiene, sampled mid-cycle.
  always @(negedge clk) begin
    logic        ok;
    logic [19:0] e;
    if (rst_n) begin
      ok = !(rd_en && wr_en) && !(done && (rd_en || wr_en || busy)) &&
           (rd_en || rd_addr == 4'd0) &&
           (wr_en || (wr_addr == 4'd0 && wr_data == 16'd0)) &&
           (grad_clear_en == wr_en) && (grad_clear_addr == wr_addr);
      n_checks++;
      if (!ok) $display("FAIL strobes: rd=%b/%h wr=%b/%h/%h clr=%b/%h done=%b busy=%b", rd_en, rd_addr,
                        wr_en, wr_addr, wr_data, grad_clear_en, grad_clear_addr, done, busy);
      else n_pass++;
      if (wr_en) begin
        n_writes++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL write: unexpected write addr=%h data=%h, required none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e)
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                     wr_addr, wr_data, e[19:16], e[15:0]);
          else n_pass++;
        end
      end
    end
  end

  // Push the expected sweep, then pulse start; returns at cycle 1 (+1 time unit).
  task automatic kick(input logic [15:0] lr_v);
    for (int i = 0; i < N; i++) exp_q.push_back({4'(i), model_upd(mem_w[i], mem_g[i], lr_v)});
    start = 1'b1;
    lr    = lr_v;
    @(posedge clk); #1;
    start = 1'b0;
    lr    = 16'($urandom);
  endtask

  // Waits for done; cyc is the cycle number of the done pulse or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin
        cyc = c;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      mem_w[i] = 16'($urandom);
      mem_g[i] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, grad_clear_en, grad_clear_addr} !== 33'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b data=%h, required all 0",
               busy, done, rd_en, wr_en, wr_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] lr_t [4]  = '{16'h0080, 16'h0001, 16'h0100, 16'h7FFF};
    logic [15:0] w0_t [4]  = '{16'h0100, 16'h0010, 16'h8000, 16'h0000};
    logic [15:0] g0_t [4]  = '{16'h0080, 16'h0080, 16'h7FFF, 16'h7FFF};
    logic [15:0] e0_t [4]  = '{16'h00C0, 16'h000F, 16'h8000, 16'h8001};
    logic [15:0] e1_t [4]  = '{16'h0050, 16'h0010, 16'h0090, 16'h400F};
    int cyc;
    for (int k = 0; k < 4; k++) begin
      fill_random();
      mem_w[0] = w0_t[k];
      mem_g[0] = g0_t[k];
      mem_w[1] = 16'h0010;
      mem_g[1] = 16'hFF80;
      kick(lr_t[k]);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 49) $display("FAIL directed_done[%0d]: done at cycle %0d, required 49", k, cyc);
      else n_pass++;
      n_checks++;
      if (mem_w[0] !== e0_t[k]) $display("FAIL directed_w0[%0d]: got %h, required %h", k, mem_w[0], e0_t[k]);
      else n_pass++;
      n_checks++;
      if (mem_w[1] !== e1_t[k]) $display("FAIL directed_w1[%0d]: got %h, required %h", k, mem_w[1], e1_t[k]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_sweep();
    int w0;
    fill_random();
    w0 = n_writes;
    kick(16'($urandom));
    for (int c = 1; c <= 52; c++) begin
      n_checks++;
      if (busy !== (c <= 48)) $display("FAIL sweep_busy: cycle %0d busy=%b, required %b", c, busy, c <= 48);
      else n_pass++;
      n_checks++;
      if (done !== (c == 49)) $display("FAIL sweep_done: cycle %0d done=%b, required %b", c, done, c == 49);
      else n_pass++;
      if (c == 25) begin
        start = 1'b1;
        lr    = 16'($urandom);
      end
      if (c == 26) start = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_writes - w0 !== 16 || exp_q.size() !== 0)
      $display("FAIL sweep_count: writes=%0d pending=%0d, required 16 and 0", n_writes - w0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0, cyc;
    logic [15:0] saved5;
    logic seen_done;
    fill_random();
    saved5 = mem_w[5];
    w0 = n_writes;
    kick(16'($urandom));
    repeat (17) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd5) $display("FAIL mid_pre: wr_en=%b addr=%h, required 1/5", wr_en, wr_addr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, grad_clear_en, grad_clear_addr} !== 33'd0)
      $display("FAIL mid_outputs: wr=%b clr=%b data=%h busy=%b, required all 0", wr_en, grad_clear_en, wr_data, busy);
    else n_pass++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) $display("FAIL mid_no_done: done/busy seen after abort, required none");
    else n_pass++;
    n_checks++;
    if (n_writes - w0 !== 5 || mem_w[5] !== saved5)
      $display("FAIL mid_writes: writes=%0d w5=%h, required 5 and %h", n_writes - w0, mem_w[5], saved5);
    else n_pass++;
    w0 = n_writes;
    kick(16'($urandom));
    wait_done(cyc);
    n_checks++;
    if (cyc !== 49 || n_writes - w0 !== 16 || exp_q.size() !== 0)
      $display("FAIL mid_restart: done at %0d writes=%0d pending=%0d, required 49/16/0", cyc, n_writes - w0, exp_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc, w0;
    fill_random();
    w0 = n_writes;
    kick(16'h0040);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 49) $display("FAIL b2b_first: done at %0d, required 49", cyc);
    else n_pass++;
    @(posedge clk); #1;
    kick(16'hFF00);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b, required 1", busy);
    else n_pass++;
    wait_done(cyc);
    n_checks++;
    if (cyc !== 49 || n_writes - w0 !== 32 || exp_q.size() !== 0)
      $display("FAIL b2b_second: done at %0d writes=%0d pending=%0d, required 49/32/0", cyc, n_writes - w0, exp_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_writes = 0;
    start    = 1'b0;
    lr       = 16'h0000;
    fill_random();
    test_reset();
    test_directed();
    test_full_sweep();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
